slow_tick_countdown: RTL
========================

# slow_tick_countdown

Consumer side of the clock divider's `slow_clk`. It brings the divider's toggle output into the fast `clk` domain through a synchronizer and turns its edges into single-cycle `tick` enables. Those ticks drive a loadable down-counter that the game FSM uses for round and mole-visibility timeouts. The divider's output is only ever used as data, never as a clock, so all game logic stays on `clk`.

## Interface
- `SYNC_STAGES`, 2: flip-flops in the `slow_clk_in` synchronizer chain; legal range 2–4.
- `CNT_WIDTH`, 8: width of `load_value` and `count`.

- `clk` input 1: fast system clock, 100 MHz; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-low; asserting low clears all state immediately; deassertion is synchronous to `clk` at board level.
- `slow_clk_in` input 1: divider `slow_clk`; treated as asynchronous.
- `start` input 1: one-cycle pulse; loads `load_value` and starts counting.
- `pause` input 1: level; while high, ticks are not counted.
- `load_value` input CNT_WIDTH: countdown start value, in ticks; sampled only when `start`=1.
- `tick` output 1: one-cycle pulse per counted `slow_clk_in` edge; free-running in every state.
- `count` output CNT_WIDTH: remaining ticks.
- `running` output 1: high in RUN and PAUSED.
- `done` output 1: one-cycle pulse when the countdown reaches 0.
- `expired` output 1: level; high in EXPIRED.

## Operation
Edge detection:
- `slow_clk_in` passes through `SYNC_STAGES` registers, then one history register.
- `tick` is registered: it is 1 when the synchronizer output is 1 and the history register is 0.

States:
- IDLE: reset state; `count` holds its value; ticks are ignored.
- RUN: on `tick`=1, `count` decrements by 1. When the decrement takes `count` from 1 to 0, pulse `done` and go to EXPIRED.
- PAUSED: entered from RUN when `pause`=1; returns to RUN when `pause`=0; ticks are ignored and `count` holds.
- EXPIRED: `expired`=1; `count`=0; stays here until `start`.

`start` (accepted in any state):
- Loads `count <= load_value`.
- Goes to RUN, or to PAUSED if `pause`=1 in the same cycle.
- Clears `expired`.
- `start` with `load_value`=0 goes straight to EXPIRED and pulses `done` on the next edge.

Priority, highest first: `reset` > `start` > `pause` > `tick`. A `tick` coincident with `start` is not counted.

Count arithmetic:
- `count` never wraps below 0; a tick in EXPIRED has no effect.
- A `done` pulse never lasts longer than one cycle.

`pause` never generates `done`, even with `count`=1.

Reset mid-count: all outputs drop to their reset values asynchronously, state returns to IDLE, and any in-flight synchronizer edge is discarded.

## Timing
- Reset values: `tick`=0, `count`=0, `running`=0, `done`=0, `expired`=0; synchronizer and history registers = 0.
- If `slow_clk_in` is high at reset release, one `tick` follows `SYNC_STAGES`+1 cycles later. This is harmless because IDLE ignores ticks.
- Edge to tick: a `slow_clk_in` rise first sampled at clk edge N gives `tick`=1 during the cycle after edge N+`SYNC_STAGES`. With the default of 2 stages, that is 3 cycles of latency.
- Tick to count: `count` updates on the clk edge that samples `tick`=1, i.e. one cycle after the `tick` pulse is visible.
- `done` and `expired` assert together with `count` becoming 0.
- Start to count: `start` sampled at edge N gives `count`=`load_value` and `running`=1 after edge N.
- `slow_clk_in` high and low phases must each be at least `SYNC_STAGES`+1 `clk` cycles; faster input is unsupported.

## Configuration
- `TICK_BOTH_EDGES_EN` defined:
  - `tick` pulses on both rising and falling synchronized edges of `slow_clk_in`.
  - Result: one tick per divider toggle, i.e. every `DIV_FACTOR`+1 `clk` cycles.
- Not defined:
  - Rising edges only; one tick per full `slow_clk_in` period.
  - The falling-edge detect logic is absent.

## Test plan
- Reset and idle: hold `reset` low, toggle `slow_clk_in` → all outputs 0. Release, then rise `slow_clk_in` → `tick` pulses once after 3 cycles; `count` stays 0; state stays IDLE.
- Normal countdown: `start` with `load_value`=3, then 3 `slow_clk_in` rises → `count` goes 3, 2, 1, 0; `done` is a single-cycle pulse on the 0 transition; `expired`=1; `running`=0.
- Pause: `load_value`=5, 2 ticks, hold `pause` for 4 ticks, release, 3 ticks → `count` stays at 3 during the pause and ends at 0 with exactly one `done`.
- Collisions:
  - `start` coincident with `tick` in RUN → `count`=`load_value`, no decrement.
  - `start` with `load_value`=0 → `done` next cycle, then EXPIRED.
- Reset mid-count: `load_value`=10, 4 ticks, pulse `reset` low asynchronously between clk edges → `count`=0 and `running`=0 immediately; further ticks leave IDLE unchanged.
- Macro: with `TICK_BOTH_EDGES_EN` defined, `load_value`=4 expires after 2 full `slow_clk_in` periods; without it, after 4 periods.

Source files
------------

// File: rtl/slow_tick_countdown.sv
// rtl/slow_tick_countdown.sv - synchronizes the divider slow_clk into ticks that drive a loadable countdown
// Optional feature macro: TICK_BOTH_EDGES_EN (tick on both synchronized edges of i_slow_clk_in)
module slow_tick_countdown #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_slow_clk_in,
  input  logic                 i_start,
  input  logic                 i_pause,
  input  logic [CNT_WIDTH-1:0] i_load_value,
  output logic                 o_tick,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_running,
  output logic                 o_done,
  output logic                 o_expired
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_tick;
  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_count;
  logic                   r_done;

  logic                   w_sync;
  logic                   w_edge;
  state_t                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   w_count_nxt;
  logic                   w_done_nxt;

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef TICK_BOTH_EDGES_EN
  assign w_edge = w_sync ^ r_hist;
`else
  assign w_edge = w_sync & ~r_hist;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync <= '0;
      r_hist <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_slow_clk_in};
      r_hist <= w_sync;
      r_tick <= w_edge;
    end
  end

  // Priority: start > pause > tick; a tick arriving with start is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    if (i_start) begin
      w_count_nxt = i_load_value;
      if (i_load_value == '0) begin
        w_state_nxt = S_EXPIRED;
        w_done_nxt  = 1'b1;
      end else if (i_pause) begin
        w_state_nxt = S_PAUSED;
      end else begin
        w_state_nxt = S_RUN;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (i_pause) begin
            w_state_nxt = S_PAUSED;
          end else if (r_tick && (r_count != '0)) begin
            w_count_nxt = r_count - CNT_WIDTH'(1);
            if (r_count == CNT_WIDTH'(1)) begin
              w_state_nxt = S_EXPIRED;
              w_done_nxt  = 1'b1;
            end
          end
        end
        S_PAUSED: begin
          if (!i_pause) begin
            w_state_nxt = S_RUN;
          end
        end
        S_EXPIRED: begin
          w_count_nxt = '0;
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign o_tick    = r_tick;
  assign o_count   = r_count;
  assign o_done    = r_done;
  assign o_running = (r_state == S_RUN) || (r_state == S_PAUSED);
  assign o_expired = (r_state == S_EXPIRED);

endmodule
